mem_port_arbiter: RTL and testbench

- Arbitrates a single-port data memory shared by the instruction-fetch stage and the MEM stage of the pipelined RV32 core.
- Serialises accesses, drives the memory address/data/func3/write-enable, and returns read data with a one-cycle done pulse.
- Generates per-requester stall signals for the hazard logic.
- Priority goes to data accesses, with a starvation guard for fetch.

---
 rtl/mem_port_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shared data-memory port arbiter for the fetch and MEM stages: data-first priority with a fetch starvation guard.
// Optional perf counters (conflictCnt, forcedCnt) exist when ARB_PERF_CNT_EN is defined.
module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ifReq,
  input  logic [31:0] ifAddr,
  output logic        ifDone,
  output logic [31:0] ifRdata,
  input  logic        dReq,
  input  logic [31:0] dAddr,
  input  logic        dWe,
  input  logic [31:0] dWdata,
  input  logic [2:0]  dFunc3,
  output logic        dDone,
  output logic [31:0] dRdata,
  output logic        ifStall,
  output logic        dStall,
  output logic [31:0] memAddr,
  output logic        memWe,
  output logic [31:0] memWdata,
  output logic [2:0]  memFunc3,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0] conflictCnt,
  output logic [31:0] forcedCnt,
`endif
  input  logic [31:0] memRdata
);

  localparam int unsigned LAT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_e;
  typedef enum logic {OWN_IF, OWN_D} owner_e;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [2:0]          func3_q, func3_d;
  logic                we_q, we_d;
  logic                mem_we_q, mem_we_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                if_done_q, if_done_d;
  logic                d_done_q, d_done_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic [31:0]         d_rdata_q, d_rdata_d;
  logic                conflict, forced, grant_d, grant_if;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    func3_d    = func3_q;
    we_d       = we_q;
    mem_we_d   = 1'b0;
    lat_d      = lat_q;
    starve_d   = starve_q;
    if_done_d  = 1'b0;
    d_done_d   = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    conflict   = 1'b0;
    forced     = 1'b0;
    grant_d    = 1'b0;
    grant_if   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        conflict = ifReq && dReq;
        forced   = conflict && (starve_q == STARVE_W'(STARVE_LIMIT));
        grant_d  = dReq && !forced;
        grant_if = ifReq && !grant_d;
        if (grant_d) begin
          owner_d  = OWN_D;
          addr_d   = dAddr;
          wdata_d  = dWdata;
          func3_d  = dFunc3;
          we_d     = dWe;
          mem_we_d = dWe;
          if (ifReq && (starve_q != STARVE_W'(STARVE_LIMIT)))
            starve_d = starve_q + 1'b1;
        end else if (grant_if) begin
          owner_d  = OWN_IF;
          addr_d   = ifAddr;
          wdata_d  = '0;
          func3_d  = 3'b010;
          we_d     = 1'b0;
          starve_d = '0;
        end
        if (grant_d || grant_if) begin
          state_d = ST_ACCESS;
          lat_d   = LAT_W'(MEM_LATENCY - 1);
        end
      end
      ST_ACCESS: begin
        if (lat_q == '0) begin
          state_d = ST_RESP;
          if (owner_q == OWN_D) begin
            d_done_d = 1'b1;
            if (!we_q) d_rdata_d = memRdata;
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = memRdata;
          end
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_IF;
      addr_q     <= '0;
      wdata_q    <= '0;
      func3_q    <= '0;
      we_q       <= 1'b0;
      mem_we_q   <= 1'b0;
      lat_q      <= '0;
      starve_q   <= '0;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      func3_q    <= func3_d;
      we_q       <= we_d;
      mem_we_q   <= mem_we_d;
      lat_q      <= lat_d;
      starve_q   <= starve_d;
      if_done_q  <= if_done_d;
      d_done_q   <= d_done_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] conflict_cnt_q, conflict_cnt_d;
  logic [31:0] forced_cnt_q, forced_cnt_d;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q + (conflict ? 32'd1 : 32'd0);
    forced_cnt_d   = forced_cnt_q + (forced ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict_cnt_q <= '0;
      forced_cnt_q   <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
      forced_cnt_q   <= forced_cnt_d;
    end
  end

  assign conflictCnt = conflict_cnt_q;
  assign forcedCnt   = forced_cnt_q;
`endif

  // memWe comes from a flop so an asynchronous reset drops it mid-access.
  assign memWe    = mem_we_q;
  assign memAddr  = addr_q;
  assign memWdata = wdata_q;
  assign memFunc3 = func3_q;
  assign ifDone   = if_done_q;
  assign dDone    = d_done_q;
  assign ifRdata  = if_rdata_q;
  assign dRdata   = d_rdata_q;
  assign ifStall  = ifReq & ~if_done_q;
  assign dStall   = dReq & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized requesters against a
// transaction-level model of the arbitration and timing rules.
module tb_mem_port_arbiter;
  localparam int unsigned ML = 2;
  localparam int unsigned SL = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifReq, dReq, dWe;
  logic [31:0] ifAddr, dAddr, dWdata;
  logic [2:0]  dFunc3;
  logic        ifDone, dDone, ifStall, dStall, memWe;
  logic [31:0] ifRdata, dRdata, memAddr, memWdata, memRdata;
  logic [2:0]  memFunc3;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] conflictCnt, forcedCnt;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  mem_port_arbiter #(.MEM_LATENCY(ML), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifDone(ifDone), .ifRdata(ifRdata),
    .dReq(dReq), .dAddr(dAddr), .dWe(dWe), .dWdata(dWdata), .dFunc3(dFunc3),
    .dDone(dDone), .dRdata(dRdata), .ifStall(ifStall), .dStall(dStall),
    .memAddr(memAddr), .memWe(memWe), .memWdata(memWdata), .memFunc3(memFunc3),
`ifdef ARB_PERF_CNT_EN
    .conflictCnt(conflictCnt), .forcedCnt(forcedCnt),
`endif
    .memRdata(memRdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h10) return 32'h00500093;
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  // Memory with ML cycles from address to data: one register stage for ML=2.
  logic [31:0] mem_pipe = '0;
  always @(posedge clk) mem_pipe <= memAddr;
  assign memRdata = mem_word(mem_pipe);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 = free, 1..ML = access cycles, ML+1 = response cycle.
  int unsigned m_phase, m_starve;
  bit          m_data, m_we, fetch_wins;
  logic [31:0] m_addr, m_wdata, m_ifr, m_dr, m_conf, m_forced;
  logic [2:0]  m_func3;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_starve = 0; m_data = 0; m_we = 0;
      m_addr = '0; m_wdata = '0; m_func3 = '0; m_ifr = '0; m_dr = '0;
      m_conf = '0; m_forced = '0;
    end else if (m_phase == 0) begin
      if (ifReq || dReq) begin
        fetch_wins = ifReq && (!dReq || m_starve == SL);
        if (ifReq && dReq) m_conf = m_conf + 1;
        if (fetch_wins && dReq) m_forced = m_forced + 1;
        if (fetch_wins) begin
          m_data = 0; m_addr = ifAddr; m_we = 0; m_func3 = 3'b010; m_starve = 0;
        end else begin
          m_data = 1; m_addr = dAddr; m_we = dWe; m_wdata = dWdata; m_func3 = dFunc3;
          if (ifReq && m_starve < SL) m_starve++;
        end
        m_phase = 1;
      end
    end else if (m_phase <= ML) begin
      if (m_phase == ML) begin
        if (!m_data) m_ifr = mem_word(m_addr);
        else if (!m_we) m_dr = mem_word(m_addr);
      end
      m_phase++;
    end else begin
      m_phase = 0;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("ifDone", ifDone, (m_phase == ML + 1) && !m_data);
      check("dDone", dDone, (m_phase == ML + 1) && m_data);
      check("ifRdata", ifRdata, m_ifr);
      check("dRdata", dRdata, m_dr);
      check("memWe", memWe, (m_phase == 1) && m_we);
      check("memAddr", memAddr, m_addr);
      check("memFunc3", memFunc3, m_func3);
      if (m_data && m_phase >= 1 && m_phase <= ML) check("memWdata", memWdata, m_wdata);
      check("ifStall", ifStall, ifReq && !((m_phase == ML + 1) && !m_data));
      check("dStall", dStall, dReq && !((m_phase == ML + 1) && m_data));
`ifdef ARB_PERF_CNT_EN
      check("conflictCnt", conflictCnt, m_conf);
      check("forcedCnt", forcedCnt, m_forced);
`endif
    end
  end

  int unsigned n, k, we_cnt, dn;
  bit          got, we_seen;
  logic [3:0]  order;

  initial begin
    reset = 1'b1; ifReq = 0; dReq = 0; dWe = 0;
    ifAddr = '0; dAddr = '0; dWdata = '0; dFunc3 = '0;
    @(negedge clk);
    check("rst_memAddr", memAddr, 32'h0);
    check("rst_memWe", memWe, 32'h0);
    check("rst_dones", {ifDone, dDone}, 32'h0);
    check("rst_rdata", ifRdata | dRdata, 32'h0);
    check("rst_func3", memFunc3, 32'h0);
    #1 reset = 1'b0;

    // Single fetch
    @(negedge clk); #1 ifAddr = 32'h10; ifReq = 1;
    n = 0; got = 0; we_seen = 0;
    while (!got && n < 20) begin
      @(posedge clk); n++;
      @(negedge clk); #1;
      if (memWe) we_seen = 1;
      if (ifDone) got = 1;
    end
    check("fetch_latency", n, ML + 1);
    check("fetch_rdata", ifRdata, 32'h00500093);
    check("fetch_func3", memFunc3, 32'h2);
    check("fetch_no_we", we_seen, 32'h0);
    ifReq = 0;

    // Single store
    @(negedge clk); #1 dAddr = 32'h100; dWe = 1; dWdata = 32'hDEADBEEF; dFunc3 = 3'b010; dReq = 1;
    n = 0; got = 0; we_cnt = 0;
    while (!got && n < 20) begin
      @(posedge clk); n++;
      @(negedge clk); #1;
      if (memWe) begin
        we_cnt++;
        check("store_addr", memAddr, 32'h100);
        check("store_wdata", memWdata, 32'hDEADBEEF);
      end
      if (dDone) got = 1;
    end
    check("store_done", got, 32'h1);
    check("store_we_cycles", we_cnt, 32'h1);
    check("store_drdata", dRdata, 32'h0);
    dReq = 0; dWe = 0;

    // Starvation: fetch held, data re-requested after each done
    @(negedge clk); #1 reset = 1;
    #2 reset = 0;
    @(negedge clk); #1 ifAddr = 32'h40; ifReq = 1; dAddr = 32'h80; dWe = 0; dFunc3 = 3'b010; dReq = 1;
    k = 0; n = 0; order = '0;
    while (k < 4 && n < 100) begin
      @(negedge clk); #1; n++;
      if (dDone) begin order[k] = 1'b1; k++; if (k >= 4) dReq = 0; end
      if (ifDone) begin order[k] = 1'b0; k++; ifReq = 0; end
    end
    check("starve_count", k, 32'h4);
    check("starve_order", order, 32'hB);
`ifdef ARB_PERF_CNT_EN
    check("perf_conflict", conflictCnt, 32'h3);
    check("perf_forced", forcedCnt, 32'h1);
`endif
    dReq = 0;

    // Async reset with a store in flight
    @(negedge clk); #1 dAddr = 32'h300; dWe = 1; dWdata = 32'h12345678; dFunc3 = 3'b010; dReq = 1;
    @(posedge clk); #2;
    check("rst_pre_we", memWe, 32'h1);
    reset = 1; #1;
    check("rst_we_drop", memWe, 32'h0);
    dReq = 0; dWe = 0;
    @(negedge clk); #1 reset = 0;
    dn = 0;
    repeat (4) begin @(negedge clk); #1; if (dDone) dn++; end
    check("rst_no_done", dn, 32'h0);
    dAddr = 32'h200; dWe = 0; dReq = 1;
    n = 0; got = 0;
    while (!got && n < 20) begin @(negedge clk); #1; n++; if (dDone) got = 1; end
    check("post_rst_done", got, 32'h1);
    check("post_rst_rdata", dRdata, mem_word(32'h200));
    dReq = 0;

    // Randomized requesters
    repeat (3000) begin
      @(negedge clk); #1;
      if (!ifReq) begin
        if ($urandom_range(0, 2) == 0) begin ifReq = 1; ifAddr = $urandom & 32'h0000_0FFC; end
      end else if (ifDone) begin
        if ($urandom_range(0, 1) == 0) ifReq = 0;
        else ifAddr = $urandom & 32'h0000_0FFC;
      end else if ($urandom_range(0, 39) == 0) ifReq = 0;
      if (!dReq || dDone) begin
        if (dDone && $urandom_range(0, 3) == 0) dReq = 0;
        else if ($urandom_range(0, 1) == 0) begin
          dReq = 1; dAddr = $urandom & 32'h0000_0FFF; dWe = 1'($urandom_range(0, 1));
          dWdata = $urandom; dFunc3 = 3'($urandom_range(0, 7));
        end else if (dDone) dReq = 0;
      end else if ($urandom_range(0, 39) == 0) dReq = 0;
    end
    ifReq = 0; dReq = 0;
    repeat (6) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
